// File: rtl/dot_product_row_scheduler_if.sv
// dot_product_row_scheduler_if: job descriptor and result handshakes between the matrix controller and the row scheduler
interface dot_product_row_scheduler_if #(
    parameter int ADDR_WIDTH    = 10,
    parameter int ELEMENT_WIDTH = 32
);
    logic                     job_valid;
    logic                     job_ready;
    logic [ADDR_WIDTH-1:0]    job_base_addr;
    logic [31:0]              job_len;
    logic                     res_valid;
    logic                     res_ready;
    logic [ELEMENT_WIDTH-1:0] res_data;
    modport master (output job_valid, job_base_addr, job_len, res_ready, input job_ready, res_valid, res_data);
    modport slave  (input job_valid, job_base_addr, job_len, res_ready, output job_ready, res_valid, res_data);
endinterface

// File: rtl/dot_product_row_scheduler.sv
// dot_product_row_scheduler: paces row-chunk pairs into the dot-product engine and returns its result; DP_SCHED_WATCHDOG_EN adds a DRAIN timeout
module dot_product_row_scheduler #(
    parameter int NO_OF_UNITS    = 8,
    parameter int ELEMENT_WIDTH  = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int ISSUE_GAP      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                   clk,
    input  logic                                   reset,
    dot_product_row_scheduler_if.slave             host,
    output logic                                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                  mem_rd_addr,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   mem_first_row,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   mem_second_row,
    output logic                                   dp_reset,
    output logic [31:0]                            dp_no_of_multiples,
    output logic                                   dp_read_now,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   dp_first_row,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   dp_second_row,
    input  logic                                   dp_finish,
    input  logic [ELEMENT_WIDTH-1:0]               dp_result,
    output logic                                   busy,
    output logic                                   err
);
    localparam int GW = $clog2(ISSUE_GAP + 1);
    typedef enum logic [2:0] {IDLE, SETUP, STREAM, DRAIN, RESULT} state_t;
    state_t                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                base_q, addr_q;
    logic [31:0]                          len_q, cnt_q, multiples_q;
    logic [GW-1:0]                        gap_q;
    logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] first_q, second_q;
    logic [ELEMENT_WIDTH-1:0]             res_q;
    logic                                 read_now_q, finish_q, err_q, finish_edge, timeout;
    assign finish_edge = dp_finish && !finish_q;
`ifdef DP_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q;
    // count cycles spent waiting for the engine, restarting on every DRAIN entry
    always_ff @(posedge clk) begin
        wd_q <= (reset || state_q != DRAIN) ? '0 : wd_q + 1'b1;
    end
    assign timeout = (state_q == DRAIN) && (wd_q == WW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif
    assign host.job_ready    = state_q == IDLE;
    assign host.res_valid    = state_q == RESULT;
    assign host.res_data     = res_q;
    assign busy              = state_q != IDLE;
    assign dp_reset          = state_q == SETUP;
    assign dp_read_now       = read_now_q;
    assign dp_no_of_multiples = multiples_q;
    assign mem_rd_addr       = addr_q;
    assign err               = err_q;
    // RAM data lands in the strobe cycle, so forward it alongside the strobe and hold it afterwards
    assign dp_first_row      = read_now_q ? mem_first_row : first_q;
    assign dp_second_row     = read_now_q ? mem_second_row : second_q;
    // state register
    always_ff @(posedge clk) begin
        state_q <= reset ? IDLE : state_d;
    end
    // next-state and RAM read issue; a read is issued once the gap since the last one has elapsed
    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        case (state_q)
            IDLE:    if (host.job_valid) state_d = (host.job_len == '0) ? RESULT : SETUP;
            SETUP:   state_d = STREAM;
            STREAM: begin
                mem_rd_en = (gap_q == '0) && (cnt_q != len_q);
                if (read_now_q && cnt_q == len_q) state_d = DRAIN;
            end
            DRAIN:   if (finish_edge || timeout) state_d = RESULT;
            RESULT:  if (host.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // job latching, chunk pacing, operand hold and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            multiples_q <= '0;
            gap_q       <= '0;
            first_q     <= '0;
            second_q    <= '0;
            res_q       <= '0;
            read_now_q  <= 1'b0;
            finish_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            finish_q   <= dp_finish;
            read_now_q <= mem_rd_en;
            err_q      <= 1'b0;
            if (state_q == IDLE && host.job_valid) begin
                base_q <= host.job_base_addr;
                len_q  <= host.job_len;
                if (host.job_len == '0) begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end
            end
            if (state_q == SETUP) begin
                multiples_q <= len_q;
                cnt_q       <= '0;
                addr_q      <= base_q;
                gap_q       <= '0;
            end
            if (mem_rd_en) begin
                cnt_q  <= cnt_q + 1'b1;
                addr_q <= addr_q + 1'b1;
                gap_q  <= GW'(ISSUE_GAP - 1);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
            if (read_now_q) begin
                first_q  <= mem_first_row;
                second_q <= mem_second_row;
            end
            if (state_q == DRAIN && finish_edge) begin
                res_q <= dp_result;
            end else if (timeout) begin
                res_q <= '1;
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dot_product_row_scheduler.sv
// tb_dot_product_row_scheduler: directed checks of job pacing, wrap, zero-length, backpressure, reset abort and watchdog
module tb_dot_product_row_scheduler;
    localparam int NU = 8, EW = 32, AW = 10, RW = NU * EW, TO = 16;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    dot_product_row_scheduler_if #(.ADDR_WIDTH(AW), .ELEMENT_WIDTH(EW)) host();
    logic          mem_rd_en, dp_reset, dp_read_now, busy, err;
    logic [AW-1:0] mem_rd_addr;
    logic [RW-1:0] mem_first_row = '0, mem_second_row = '0, dp_first_row, dp_second_row;
    logic [31:0]   dp_no_of_multiples;
    logic          dp_finish = 1'b0;
    logic [EW-1:0] dp_result = '0;
    logic [RW-1:0] ram_a [1024];
    logic [RW-1:0] ram_b [1024];
    int cyc = 0, n_dpreset = 0, n_cmp = 0, n_bad = 0;
    int strobe_cyc[$];
    logic [31:0] strobe_row[$];
    int rd_addr[$];

    dot_product_row_scheduler #(.NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .ISSUE_GAP(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .host(host),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_first_row(mem_first_row), .mem_second_row(mem_second_row),
        .dp_reset(dp_reset), .dp_no_of_multiples(dp_no_of_multiples), .dp_read_now(dp_read_now),
        .dp_first_row(dp_first_row), .dp_second_row(dp_second_row), .dp_finish(dp_finish), .dp_result(dp_result),
        .busy(busy), .err(err)
    );

    // operand RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_first_row  <= ram_a[mem_rd_addr];
            mem_second_row <= ram_b[mem_rd_addr];
        end
    end

    // cycle counter and event logs; cyc names the cycle that just ended
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_read_now) begin
            strobe_cyc.push_back(cyc);
            strobe_row.push_back(dp_first_row[31:0]);
        end
        if (mem_rd_en) rd_addr.push_back(int'(mem_rd_addr));
        if (dp_reset) n_dpreset <= n_dpreset + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [31:0] n, output int t);
        int k = 0;
        while (!host.job_ready && k < 50) begin step(); k++; end
        n_cmp++; if (host.job_ready !== 1'b1) begin n_bad++; $display("FAIL job_accept: job_ready=%b required 1", host.job_ready); end
        host.job_valid = 1'b1; host.job_base_addr = b; host.job_len = n;
        t = cyc;
        step();
        host.job_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int target);
        int k = 0;
        while (strobe_cyc.size() < target && k < 100) begin step(); k++; end
        n_cmp++; if (strobe_cyc.size() != target) begin n_bad++; $display("FAIL wait_strobes: got %0d required %0d", strobe_cyc.size(), target); end
    endtask

    task automatic finish_now(input logic [31:0] r);
        dp_result = r; dp_finish = 1'b1;
        step();
        dp_finish = 1'b0;
    endtask

    task automatic handshake();
        host.res_ready = 1'b1;
        step();
        host.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        n_cmp++; if ({host.job_ready, busy, host.res_valid, dp_reset, dp_read_now, mem_rd_en, err} !== 7'b1000000) begin n_bad++; $display("FAIL reset_flags: got %b required 1000000", {host.job_ready, busy, host.res_valid, dp_reset, dp_read_now, mem_rd_en, err}); end
        n_cmp++; if ({host.res_data, dp_no_of_multiples, 22'(mem_rd_addr)} !== 86'd0) begin n_bad++; $display("FAIL reset_words: res_data=%h mult=%h addr=%h required 0", host.res_data, dp_no_of_multiples, mem_rd_addr); end
        n_cmp++; if ({dp_first_row, dp_second_row} !== '0) begin n_bad++; $display("FAIL reset_rows: got %h required 0", dp_first_row); end
        reset = 1'b0;
        step();
        n_cmp++; if ({host.job_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL reset_release: got %b required 10", {host.job_ready, busy}); end
    endtask

    task automatic test_single();
        int t, bs;
        bs = strobe_cyc.size();
        start_job(10'd0, 32'd1, t);
        n_cmp++; if ({dp_reset, busy, host.job_ready} !== 3'b110) begin n_bad++; $display("FAIL single_setup: got %b required 110", {dp_reset, busy, host.job_ready}); end
        step();
        n_cmp++; if ({mem_rd_en, mem_rd_addr} !== {1'b1, 10'd0}) begin n_bad++; $display("FAIL single_rd: en=%b addr=%0d required 1/0", mem_rd_en, mem_rd_addr); end
        n_cmp++; if (dp_no_of_multiples !== 32'd1) begin n_bad++; $display("FAIL single_mult: got %0d required 1", dp_no_of_multiples); end
        step();
        n_cmp++; if (dp_read_now !== 1'b1) begin n_bad++; $display("FAIL single_strobe: got %b required 1", dp_read_now); end
        n_cmp++; if ({dp_first_row, dp_second_row} !== {2*RW{1'b1}}) begin n_bad++; $display("FAIL single_rows: got %h required all ones", dp_first_row); end
        step();
        n_cmp++; if ({dp_read_now, dp_first_row} !== {1'b0, {RW{1'b1}}}) begin n_bad++; $display("FAIL single_hold: strobe=%b row=%h required 0/all ones", dp_read_now, dp_first_row); end
        finish_now(32'h41000000);
        n_cmp++; if ({host.res_valid, host.res_data, err} !== {1'b1, 32'h41000000, 1'b0}) begin n_bad++; $display("FAIL single_result: valid=%b data=%h err=%b required 1/41000000/0", host.res_valid, host.res_data, err); end
        handshake();
        n_cmp++; if ({host.job_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL single_idle: got %b required 10", {host.job_ready, busy}); end
        n_cmp++; if (strobe_cyc.size() != bs + 1 || strobe_cyc[bs] != t + 3) begin n_bad++; $display("FAIL single_strobe_time: count=%0d at=%0d required 1 at %0d", strobe_cyc.size() - bs, strobe_cyc[bs], t + 3); end
    endtask

    task automatic test_wrap();
        int t, bs, br;
        int exp_addr[4] = '{1022, 1023, 0, 1};
        logic [31:0] exp_row[4] = '{32'h13FE, 32'h13FF, 32'hFFFFFFFF, 32'h1001};
        bs = strobe_cyc.size(); br = rd_addr.size();
        dp_finish = 1'b1;
        start_job(10'd1022, 32'd4, t);
        wait_strobes(bs + 4);
        n_cmp++; if (rd_addr.size() != br + 4) begin n_bad++; $display("FAIL wrap_rd_count: got %0d required 4", rd_addr.size() - br); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd_addr[br + i] != exp_addr[i]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, rd_addr[br + i], exp_addr[i]); end
            n_cmp++; if (strobe_cyc[bs + i] != t + 3 + 2 * i) begin n_bad++; $display("FAIL wrap_strobe_time[%0d]: got %0d required %0d", i, strobe_cyc[bs + i], t + 3 + 2 * i); end
            n_cmp++; if (strobe_row[bs + i] !== exp_row[i]) begin n_bad++; $display("FAIL wrap_row[%0d]: got %h required %h", i, strobe_row[bs + i], exp_row[i]); end
        end
        step(); step();
        n_cmp++; if (host.res_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_level_ignored: res_valid=%b required 0", host.res_valid); end
        dp_finish = 1'b0;
        step();
        finish_now(32'hCAFE0004);
        n_cmp++; if ({host.res_valid, host.res_data} !== {1'b1, 32'hCAFE0004}) begin n_bad++; $display("FAIL wrap_result: valid=%b data=%h required 1/cafe0004", host.res_valid, host.res_data); end
        handshake();
    endtask

    task automatic test_zero();
        int t, br, bd;
        br = rd_addr.size(); bd = n_dpreset;
        start_job(10'd5, 32'd0, t);
        n_cmp++; if ({host.res_valid, err, busy, host.res_data} !== {3'b111, 32'd0}) begin n_bad++; $display("FAIL zero_result: valid=%b err=%b busy=%b data=%h required 1/1/1/0", host.res_valid, err, busy, host.res_data); end
        step();
        n_cmp++; if ({host.res_valid, err} !== 2'b10) begin n_bad++; $display("FAIL zero_err_pulse: valid=%b err=%b required 1/0", host.res_valid, err); end
        handshake();
        n_cmp++; if (rd_addr.size() != br || n_dpreset != bd) begin n_bad++; $display("FAIL zero_no_activity: reads=%0d dp_resets=%0d required 0/0", rd_addr.size() - br, n_dpreset - bd); end
    endtask

    task automatic test_back_to_back();
        int t, t2, bs;
        bs = strobe_cyc.size();
        start_job(10'd2, 32'd1, t);
        wait_strobes(bs + 1);
        finish_now(32'h12345678);
        host.job_valid = 1'b1; host.job_base_addr = 10'd3; host.job_len = 32'd2;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if ({host.res_valid, host.res_data, host.job_ready} !== {1'b1, 32'h12345678, 1'b0}) begin n_bad++; $display("FAIL stall[%0d]: valid=%b data=%h job_ready=%b required 1/12345678/0", i, host.res_valid, host.res_data, host.job_ready); end
            step();
        end
        host.res_ready = 1'b1;
        step();
        host.res_ready = 1'b0;
        n_cmp++; if (host.job_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b required 1", host.job_ready); end
        t2 = cyc;
        step();
        host.job_valid = 1'b0;
        n_cmp++; if (dp_reset !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: dp_reset=%b required 1", dp_reset); end
        wait_strobes(bs + 3);
        n_cmp++; if (strobe_cyc[bs + 1] != t2 + 3 || strobe_cyc[bs + 2] != t2 + 5) begin n_bad++; $display("FAIL b2b_strobe_time: got %0d,%0d required %0d,%0d", strobe_cyc[bs + 1], strobe_cyc[bs + 2], t2 + 3, t2 + 5); end
        n_cmp++; if (strobe_row[bs + 1] !== 32'h1003 || strobe_row[bs + 2] !== 32'h1004) begin n_bad++; $display("FAIL b2b_rows: got %h,%h required 1003,1004", strobe_row[bs + 1], strobe_row[bs + 2]); end
        finish_now(32'h0BAD0002);
        n_cmp++; if ({host.res_valid, host.res_data} !== {1'b1, 32'h0BAD0002}) begin n_bad++; $display("FAIL b2b_result: valid=%b data=%h required 1/0bad0002", host.res_valid, host.res_data); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int t, bs;
        bs = strobe_cyc.size();
        start_job(10'd0, 32'd6, t);
        wait_strobes(bs + 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if ({host.job_ready, busy, host.res_valid, dp_reset, dp_read_now, mem_rd_en, err} !== 7'b1000000) begin n_bad++; $display("FAIL abort_flags: got %b required 1000000", {host.job_ready, busy, host.res_valid, dp_reset, dp_read_now, mem_rd_en, err}); end
        n_cmp++; if ({host.res_data, dp_no_of_multiples, 22'(mem_rd_addr), dp_first_row, dp_second_row} !== '0) begin n_bad++; $display("FAIL abort_words: data=%h mult=%h addr=%h required 0", host.res_data, dp_no_of_multiples, mem_rd_addr); end
        repeat (12) step();
        n_cmp++; if (strobe_cyc.size() != bs + 3 || host.res_valid !== 1'b0) begin n_bad++; $display("FAIL abort_quiet: strobes=%0d valid=%b required 3/0", strobe_cyc.size() - bs, host.res_valid); end
        start_job(10'd4, 32'd2, t);
        wait_strobes(bs + 5);
        n_cmp++; if (strobe_row[bs + 3] !== 32'h1004 || strobe_row[bs + 4] !== 32'h1005) begin n_bad++; $display("FAIL fresh_rows: got %h,%h required 1004,1005", strobe_row[bs + 3], strobe_row[bs + 4]); end
        finish_now(32'h00000777);
        n_cmp++; if ({host.res_valid, host.res_data, err} !== {1'b1, 32'h777, 1'b0}) begin n_bad++; $display("FAIL fresh_result: valid=%b data=%h err=%b required 1/777/0", host.res_valid, host.res_data, err); end
        handshake();
    endtask

`ifdef DP_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int t, bs, early;
        bs = strobe_cyc.size(); early = 0;
        start_job(10'd7, 32'd1, t);
        wait_strobes(bs + 1);
        for (int i = 0; i < TO; i++) begin
            if (host.res_valid !== 1'b0) early++;
            step();
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL wd_early: res_valid high in %0d cycles required 0", early); end
        n_cmp++; if ({host.res_valid, err, host.res_data} !== {2'b11, 32'hFFFFFFFF}) begin n_bad++; $display("FAIL wd_timeout: valid=%b err=%b data=%h required 1/1/ffffffff", host.res_valid, err, host.res_data); end
        step();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wd_err_pulse: got %b required 0", err); end
        handshake();
    endtask
`endif

    initial begin
        host.job_valid = 1'b0; host.job_base_addr = '0; host.job_len = '0; host.res_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ram_a[i] = {NU{32'(32'h1000 + i)}};
            ram_b[i] = ~ram_a[i];
        end
        ram_a[0] = '1; ram_b[0] = '1;
        test_reset();
        test_single();
        test_wrap();
        test_zero();
        test_back_to_back();
        test_reset_mid();
`ifdef DP_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish required completion");
        $fatal(1, "global timeout");
    end
endmodule
